hive_reg_spi_mc: RTL and testbench

// - Multi-chip-select, mode-programmable SPI master on the hive register bus (rbus).
// - Successor to the single-channel SPI register: parametrised CS count, programmable transfer

---
 rtl/hive_reg_spi_mc.sv | 241 ++++++++++++++++++++++++
 tb/tb_hive_reg_spi_mc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hive_reg_spi_mc.sv
// hive_reg_spi_mc: SPI master on the hive register bus with several
// active-low chip selects, programmable length, SCLK divider and CPOL/CPHA.
// Register map: CFG at BASE_ADDR, DATA at BASE_ADDR+1, STAT at BASE_ADDR+2.
module hive_reg_spi_mc #(
    parameter int RBUS_ADDR_W = 8,
    parameter int ALU_W       = 32,
    parameter int BASE_ADDR   = 'h20,
    parameter int CS_N        = 4,
    parameter int DIV_W       = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RBUS_ADDR_W-1:0] rbus_addr_i,
    input  logic                   rbus_wr_i,
    input  logic                   rbus_rd_i,
    input  logic [ALU_W-1:0]       rbus_wr_data_i,
    output logic [ALU_W-1:0]       rbus_rd_data_o,
    output logic                   scl_o,
    output logic [CS_N-1:0]        scs_o,
    output logic                   sdo_o,
    input  logic                   sdi_i,
    input  logic                   loop_i,
    output logic                   busy_o
);

    // CFG field layout
    localparam int CS_LSB  = 16;
    localparam int CS_W    = 4;
    localparam int LEN_LSB = 24;
    localparam int LEN_W   = 5;
    localparam int ECNT_W  = LEN_W + 1;

    localparam logic [RBUS_ADDR_W-1:0] A_CFG  = RBUS_ADDR_W'(BASE_ADDR);
    localparam logic [RBUS_ADDR_W-1:0] A_DATA = RBUS_ADDR_W'(BASE_ADDR + 1);
    localparam logic [RBUS_ADDR_W-1:0] A_STAT = RBUS_ADDR_W'(BASE_ADDR + 2);

    // Only the defined CFG fields are stored; the rest read back as zero
    localparam logic [ALU_W-1:0] CFG_MASK =
        ALU_W'(32'h1F0F_0000) | ALU_W'((64'd1 << (DIV_W + 2)) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Chip-select pattern for a given index; out-of-range indices select nothing
    function automatic logic [CS_N-1:0] cs_decode(input logic [CS_W-1:0] idx);
        logic [CS_N-1:0] v;
        v = '1;
        for (int i = 0; i < CS_N; i++) begin
            if (idx == CS_W'(i)) begin
                v[i] = 1'b0;
            end else begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    state_t                   state_r;
    logic [ALU_W-1:0]         cfg_r;
    logic [ALU_W-1:0]         data_r;
    logic [ALU_W-1:0]         tx_r;
    logic [ALU_W-1:0]         rx_r;
    logic                     ovf_r;
    logic                     start_r;
    logic [DIV_W-1:0]         cnt_r;
    logic [ECNT_W-1:0]        ecnt_r;
    logic                     scl_r;
    logic [CS_N-1:0]          scs_r;
    logic                     sdo_r;
    logic                     busy_r;
    logic [ALU_W-1:0]         rd_data_r;

    logic [DIV_W-1:0]         div_s;
    logic                     cpha_s;
    logic                     cpol_s;
    logic [CS_W-1:0]          cs_idx_s;
    logic [LEN_W-1:0]         len_m1_s;
    logic [LEN_W:0]           len_s;
    logic [ECNT_W-1:0]        last_edge_s;
    logic [7:0]               sh_s;
    logic [ALU_W-1:0]         tx_load_s;
    logic                     hit_cfg_s;
    logic                     hit_data_s;
    logic                     hit_stat_s;
    logic                     busy_any_s;
    logic                     sin_s;
    logic                     leading_s;

    // Field decode, address decode and transmit-word alignment
    always_comb begin
        div_s       = cfg_r[DIV_W-1:0];
        cpha_s      = cfg_r[DIV_W];
        cpol_s      = cfg_r[DIV_W+1];
        cs_idx_s    = cfg_r[CS_LSB +: CS_W];
        len_m1_s    = cfg_r[LEN_LSB +: LEN_W];
        len_s       = {1'b0, len_m1_s} + 6'd1;
        // index of the final SCLK edge is 2*len-1
        last_edge_s = {len_m1_s, 1'b1};
        // left-align the word so its MSB sits at the top of the shifter
        sh_s        = 8'(ALU_W) - {2'b00, len_s};
        tx_load_s   = rbus_wr_data_i << sh_s;
        hit_cfg_s   = (rbus_addr_i == A_CFG);
        hit_data_s  = (rbus_addr_i == A_DATA);
        hit_stat_s  = (rbus_addr_i == A_STAT);
        // a pending start counts as busy so a second DATA write cannot slip in
        busy_any_s  = busy_r | start_r;
        sin_s       = loop_i ? sdo_r : sdi_i;
        leading_s   = ~ecnt_r[0];
    end

    // Register writes, status flag and the transfer state machine
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
            cfg_r   <= '0;
            data_r  <= '0;
            tx_r    <= '0;
            rx_r    <= '0;
            ovf_r   <= 1'b0;
            start_r <= 1'b0;
            cnt_r   <= '0;
            ecnt_r  <= '0;
            scl_r   <= 1'b0;
            scs_r   <= '1;
            sdo_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    scl_r  <= cpol_s;
                    scs_r  <= '1;
                    busy_r <= 1'b0;
                    if (start_r) begin
                        start_r <= 1'b0;
                        state_r <= ST_SETUP;
                        busy_r  <= 1'b1;
                        scs_r   <= cs_decode(cs_idx_s);
                        sdo_r   <= cpha_s ? 1'b0 : tx_r[ALU_W-1];
                        rx_r    <= '0;
                        cnt_r   <= div_s;
                        ecnt_r  <= '0;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_SHIFT;
                        cnt_r   <= div_s;
                    end else begin
                        cnt_r <= cnt_r - DIV_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r == '0) begin
                        cnt_r <= div_s;
                        scl_r <= ~scl_r;
                        // CPHA=0 samples on leading edges, CPHA=1 on trailing edges
                        if (leading_s != cpha_s) begin
                            rx_r <= {rx_r[ALU_W-2:0], sin_s};
                        end else if (cpha_s) begin
                            sdo_r <= tx_r[ALU_W-1];
                            tx_r  <= tx_r << 1;
                        end else begin
                            sdo_r <= tx_r[ALU_W-2];
                            tx_r  <= tx_r << 1;
                        end
                        if (ecnt_r == last_edge_s) begin
                            state_r <= ST_HOLD;
                        end else begin
                            ecnt_r <= ecnt_r + ECNT_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r - DIV_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        scs_r   <= '1;
                        scl_r   <= cpol_s;
                        data_r  <= rx_r;
                    end else begin
                        cnt_r <= cnt_r - DIV_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    scs_r   <= '1;
                end
            endcase

            // CFG write; the idle clock level follows the new CPOL at once
            if (rbus_wr_i && hit_cfg_s && !busy_any_s) begin
                cfg_r <= rbus_wr_data_i & CFG_MASK;
                scl_r <= rbus_wr_data_i[DIV_W+1];
            end

            // STAT read clears ovf; a simultaneous overrun still sets it
            if (rbus_rd_i && hit_stat_s) begin
                ovf_r <= 1'b0;
            end

            if (rbus_wr_i && hit_data_s) begin
                if (busy_any_s) begin
                    ovf_r <= 1'b1;
                end else begin
                    tx_r    <= tx_load_s;
                    start_r <= 1'b1;
                end
            end
        end
    end

    // Registered read data: valid the cycle after a read strobe, zero otherwise
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_data_r <= '0;
        end else if (rbus_rd_i) begin
            case (rbus_addr_i)
                A_CFG:   rd_data_r <= cfg_r;
                A_DATA:  rd_data_r <= data_r;
                A_STAT:  rd_data_r <= {{(ALU_W-2){1'b0}}, ovf_r, busy_r};
                default: rd_data_r <= '0;
            endcase
        end else begin
            rd_data_r <= '0;
        end
    end

    assign rbus_rd_data_o = rd_data_r;
    assign scl_o          = scl_r;
    assign scs_o          = scs_r;
    assign sdo_o          = sdo_r;
    assign busy_o         = busy_r;

endmodule

// File: tb/tb_hive_reg_spi_mc.sv
// Directed testbench for hive_reg_spi_mc with hand-computed expectations.
module tb_hive_reg_spi_mc;

    localparam logic [7:0] A_CFG  = 8'h20;
    localparam logic [7:0] A_DATA = 8'h21;
    localparam logic [7:0] A_STAT = 8'h22;

    logic        clk;
    logic        rst_i;
    logic [7:0]  rbus_addr;
    logic        rbus_wr;
    logic        rbus_rd;
    logic [31:0] rbus_wr_data;
    logic [31:0] rbus_rd_data;
    logic        scl;
    logic [3:0]  scs;
    logic        sdo;
    logic        sdi;
    logic        loop;
    logic        busy;

    int ncomp = 0;
    int nfail = 0;

    hive_reg_spi_mc #(
        .RBUS_ADDR_W(8),
        .ALU_W      (32),
        .BASE_ADDR  ('h20),
        .CS_N       (4),
        .DIV_W      (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .rbus_addr_i   (rbus_addr),
        .rbus_wr_i     (rbus_wr),
        .rbus_rd_i     (rbus_rd),
        .rbus_wr_data_i(rbus_wr_data),
        .rbus_rd_data_o(rbus_rd_data),
        .scl_o         (scl),
        .scs_o         (scs),
        .sdo_o         (sdo),
        .sdi_i         (sdi),
        .loop_i        (loop),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        rbus_addr    = a;
        rbus_wr_data = d;
        rbus_wr      = 1'b1;
        @(posedge clk);
        #1;
        rbus_wr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        rbus_addr = a;
        rbus_rd   = 1'b1;
        @(posedge clk);
        #1;
        rbus_rd = 1'b0;
        chk(tag, rbus_rd_data, exp);
    endtask

    // Watch one transfer cycle by cycle until busy falls (bounded).
    task automatic run_xfer(input logic [3:0] scs_exp, input bit drive_sdi,
                            input logic [31:0] pat, output int fall,
                            output int rises, output logic [31:0] sdo_bits,
                            output int scs_bad, output int nbits);
        logic prev;
        fall     = 0;
        rises    = 0;
        sdo_bits = 32'h0;
        scs_bad  = 0;
        nbits    = 0;
        prev     = scl;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1) begin
                fall = cyc;
                break;
            end
            if (scs !== scs_exp) scs_bad++;
            if (prev == 1'b0 && scl == 1'b1) begin
                sdo_bits = {sdo_bits[30:0], sdo};
                rises++;
            end
            if (drive_sdi && prev == 1'b1 && scl == 1'b0 && nbits < 32) begin
                sdi = pat[31-nbits];
                nbits++;
            end
            prev = scl;
        end
    endtask

    int          fall;
    int          rises;
    int          scs_bad;
    int          nbits;
    logic [31:0] bits;

    initial begin
        rst_i        = 1'b0;
        rbus_addr    = 8'h00;
        rbus_wr      = 1'b0;
        rbus_rd      = 1'b0;
        rbus_wr_data = 32'h0;
        sdi          = 1'b0;
        loop         = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scs", 32'(scs), 32'hF);
        chk("rst_scl", 32'(scl), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sdo", 32'(sdo), 32'h0);
        chk("rst_rdata", rbus_rd_data, 32'h0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rd_chk("rst_cfg", A_CFG, 32'h0);
        rd_chk("rst_data", A_DATA, 32'h0);
        rd_chk("rst_stat", A_STAT, 32'h0);

        // Mode 0, div=1, cs=2, len=8, loopback of 'hA5
        wr(A_CFG, 32'h0702_0001);
        rd_chk("m0_cfg_rb", A_CFG, 32'h0702_0001);
        @(posedge clk);
        #1;
        chk("rd_zero_after", rbus_rd_data, 32'h0);
        loop = 1'b1;
        wr(A_DATA, 32'h0000_00A5);
        run_xfer(4'b1011, 1'b0, 32'h0, fall, rises, bits, scs_bad, nbits);
        chk("m0_fall_cyc", 32'(fall), 32'd37);
        chk("m0_rises", 32'(rises), 32'd8);
        chk("m0_sdo_bits", bits, 32'h0000_00A5);
        chk("m0_scs_bad", 32'(scs_bad), 32'd0);
        chk("m0_scs_idle", 32'(scs), 32'hF);
        chk("m0_scl_idle", 32'(scl), 32'h0);
        rd_chk("m0_data", A_DATA, 32'h0000_00A5);

        // Mode 3, div=0, len=32, sdi from 'h12345678 model
        wr(A_CFG, 32'h1F00_0300);
        chk("m3_scl_idle_cfg", 32'(scl), 32'h1);
        loop = 1'b0;
        wr(A_DATA, 32'hDEAD_BEEF);
        run_xfer(4'b1110, 1'b1, 32'h1234_5678, fall, rises, bits, scs_bad, nbits);
        chk("m3_fall_cyc", 32'(fall), 32'd67);
        chk("m3_nbits", 32'(nbits), 32'd32);
        chk("m3_scs_bad", 32'(scs_bad), 32'd0);
        chk("m3_scl_idle", 32'(scl), 32'h1);
        rd_chk("m3_data", A_DATA, 32'h1234_5678);

        // Overrun: DATA write while busy, STAT read clears ovf
        wr(A_CFG, 32'h0702_0001);
        loop = 1'b1;
        wr(A_DATA, 32'h0000_003C);
        wr(A_DATA, 32'h0000_00FF);
        rd_chk("ovf_stat1", A_STAT, 32'h3);
        rd_chk("ovf_stat2", A_STAT, 32'h1);
        wr(A_CFG, 32'h0000_0000);
        run_xfer(4'b1011, 1'b0, 32'h0, fall, rises, bits, scs_bad, nbits);
        chk("ovf_scs_bad", 32'(scs_bad), 32'd0);
        chk("ovf_rises", 32'(rises), 32'd8);
        chk("ovf_sdo_bits", bits, 32'h0000_003C);
        rd_chk("ovf_data", A_DATA, 32'h0000_003C);
        rd_chk("ovf_cfg_kept", A_CFG, 32'h0702_0001);
        rd_chk("ovf_stat_idle", A_STAT, 32'h0);

        // Out-of-range chip select index
        wr(A_CFG, 32'h0707_0001);
        wr(A_DATA, 32'h0000_005A);
        run_xfer(4'b1111, 1'b0, 32'h0, fall, rises, bits, scs_bad, nbits);
        chk("cs7_fall_cyc", 32'(fall), 32'd37);
        chk("cs7_scs_bad", 32'(scs_bad), 32'd0);
        rd_chk("cs7_data", A_DATA, 32'h0000_005A);

        // Reset mid-SHIFT
        wr(A_CFG, 32'h0702_0001);
        wr(A_DATA, 32'h0000_0081);
        repeat (12) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'h1);
        chk("pre_rst_scs", 32'(scs), 32'hB);
        #1;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_scs", 32'(scs), 32'hF);
        chk("mid_rst_scl", 32'(scl), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_sdo", 32'(sdo), 32'h0);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rd_chk("mid_rst_data", A_DATA, 32'h0);
        rd_chk("mid_rst_cfg", A_CFG, 32'h0);
        rd_chk("mid_rst_stat", A_STAT, 32'h0);

        // Simultaneous read and write of CFG: read sees the old value
        rbus_addr    = A_CFG;
        rbus_wr_data = 32'h0000_0305;
        rbus_wr      = 1'b1;
        rbus_rd      = 1'b1;
        @(posedge clk);
        #1;
        rbus_wr = 1'b0;
        rbus_rd = 1'b0;
        chk("rdwr_old", rbus_rd_data, 32'h0);
        chk("rdwr_scl_cpol", 32'(scl), 32'h1);
        rd_chk("rdwr_new", A_CFG, 32'h0000_0305);

        // STAT writes have no effect
        wr(A_STAT, 32'hFFFF_FFFF);
        rd_chk("stat_wr_noeffect", A_STAT, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
